mc_control_hs: RTL and testbench

Multicycle MIPS control unit with a memory ready handshake. It replaces the fixed-latency control FSM inside the `mips` top and drives the same datapath control signals. It also stalls on a variable-latency memory, decodes `bne`/`addi`/`j`, counts retired instructions, and can optionally trap on a memory timeout.

---
 rtl/mc_control_hs.sv | 149 ++++++++++++++
 tb/tb_mc_control_hs.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mc_control_hs.sv
// Multicycle MIPS control FSM with a memory-ready handshake, bne/addi/j decode and a retire counter.
// Define MC_CTRL_TIMEOUT_EN to trap into HALT when a memory wait state exceeds TIMEOUT cycles.
module mc_control_hs #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemToReg,
  output logic             IRWrite,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             Branch,
  output logic             BranchNe,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state_o,
  output logic             illegal,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count,
  output logic             err_timeout
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
    BRANCH = 4'd8,  JUMP   = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11,
    HALT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t state, next_state;
  logic   expire;

  assign state_o = state;

`ifdef MC_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  logic          waiting;

  assign waiting = (state == FETCH || state == MEMRD || state == MEMWR) && !mem_ready;
  assign expire  = waiting && (wait_cnt == TW'(TIMEOUT));
`else
  assign expire      = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    next_state = state;
    unique case (state)
      FETCH:  if (mem_ready) next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW:   next_state = MEMADR;
          OP_RTYPE:       next_state = EXEC;
          OP_BEQ, OP_BNE: next_state = BRANCH;
          OP_ADDI:        next_state = ADDIEX;
          OP_J:           next_state = JUMP;
          default:        next_state = FETCH;
        endcase
      end
      MEMADR: next_state = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (mem_ready) next_state = MEMWB;
      MEMWR:  if (mem_ready) next_state = FETCH;
      EXEC:   next_state = ALUWB;
      ADDIEX: next_state = ADDIWB;
      MEMWB, ALUWB, BRANCH, JUMP, ADDIWB: next_state = FETCH;
      HALT:   next_state = HALT;
      default: next_state = FETCH;
    endcase
    if (expire) next_state = HALT;
  end

  // Control outputs decode from the current state; FETCH and MEMWR also see mem_ready.
  always_comb begin
    PCWrite  = 1'b0; IorD     = 1'b0; MemRead  = 1'b0; MemWrite = 1'b0;
    MemToReg = 1'b0; IRWrite  = 1'b0; ALUSrcA  = 1'b0; RegWrite = 1'b0;
    RegDst   = 1'b0; Branch   = 1'b0; BranchNe = 1'b0; ALUSrcB  = 2'b00;
    ALUOp    = 2'b00; PCSource = 2'b00; illegal = 1'b0; retire   = 1'b0;
    unique case (state)
      FETCH: begin
        MemRead = 1'b1; ALUSrcB = 2'b01;
        IRWrite = mem_ready; PCWrite = mem_ready;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        if (!(op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J})) begin
          illegal = 1'b1; retire = 1'b1;
        end
      end
      MEMADR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
      MEMRD:  begin MemRead = 1'b1; IorD = 1'b1; end
      MEMWB:  begin MemToReg = 1'b1; RegWrite = 1'b1; retire = 1'b1; end
      MEMWR:  begin MemWrite = 1'b1; IorD = 1'b1; retire = mem_ready; end
      EXEC:   begin ALUSrcA = 1'b1; ALUOp = 2'b10; end
      ALUWB:  begin RegDst = 1'b1; RegWrite = 1'b1; retire = 1'b1; end
      BRANCH: begin
        ALUSrcA = 1'b1; ALUOp = 2'b01; PCSource = 2'b01; retire = 1'b1;
        Branch = (op == OP_BEQ); BranchNe = (op == OP_BNE);
      end
      ADDIEX: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
      ADDIWB: begin RegWrite = 1'b1; retire = 1'b1; end
      JUMP:   begin PCSource = 2'b10; PCWrite = 1'b1; retire = 1'b1; end
      HALT:   ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (retire) instr_count <= instr_count + 1'b1;
    end
  end

`ifdef MC_CTRL_TIMEOUT_EN
  // The wait counter only survives consecutive not-ready cycles in the same wait state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (waiting && !expire) wait_cnt <= wait_cnt + 1'b1;
      else                    wait_cnt <= '0;
      if (expire) err_timeout <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_control_hs.sv
// Directed self-checking bench for mc_control_hs using immediate assertions.
module tb_mc_control_hs;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op;
  logic        mem_ready;
  logic        PCWrite, IorD, MemRead, MemWrite, MemToReg, IRWrite, ALUSrcA;
  logic        RegWrite, RegDst, Branch, BranchNe, illegal, retire, err_timeout;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  state_o;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;

  mc_control_hs #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemToReg(MemToReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .Branch(Branch), .BranchNe(BranchNe), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .state_o(state_o), .illegal(illegal),
    .retire(retire), .instr_count(instr_count), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [5:0] o, input logic rdy);
    op = o;
    mem_ready = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walks one instruction: n states packed 4 bits each, retire expected only on the last one.
  task automatic expectStates(input string tag, input int n, input logic [23:0] seq);
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_state"}, 32'(state_o), 32'(seq[4*i +: 4]));
      checkOutput({tag, "_retire"}, 32'(retire), (i == n - 1) ? 32'd1 : 32'd0);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(6'h00, 1'b1);
    #10;
    checkOutput("rst_state", 32'(state_o), 32'd0);
    checkOutput("rst_memread", 32'(MemRead), 32'd1);
    checkOutput("rst_alusrcb", 32'(ALUSrcB), 32'd1);
    checkOutput("rst_irwrite", 32'(IRWrite), 32'd1);
    checkOutput("rst_count", instr_count, 32'd0);
    checkOutput("rst_err", 32'(err_timeout), 32'd0);
    #11;
    rst = 1'b0;

    applyStimulus(6'h23, 1'b1);
    expectStates("lw", 5, {4'd0, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0});
    applyStimulus(6'h2B, 1'b1);
    expectStates("sw", 4, {8'd0, 4'd5, 4'd2, 4'd1, 4'd0});
    applyStimulus(6'h00, 1'b1);
    expectStates("rtype", 4, {8'd0, 4'd7, 4'd6, 4'd1, 4'd0});
    applyStimulus(6'h08, 1'b1);
    expectStates("addi", 4, {8'd0, 4'd11, 4'd10, 4'd1, 4'd0});
    applyStimulus(6'h04, 1'b1);
    expectStates("beq", 3, {12'd0, 4'd8, 4'd1, 4'd0});
    applyStimulus(6'h02, 1'b1);
    expectStates("j", 3, {12'd0, 4'd9, 4'd1, 4'd0});
    checkOutput("stream_state", 32'(state_o), 32'd0);
    checkOutput("stream_count", instr_count, 32'd6);

    // FETCH stall: three not-ready cycles, then ready.
    applyStimulus(6'h05, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_state", 32'(state_o), 32'd0);
      checkOutput("stall_memread", 32'(MemRead), 32'd1);
      checkOutput("stall_irwrite", 32'(IRWrite), 32'd0);
      checkOutput("stall_pcwrite", 32'(PCWrite), 32'd0);
      tick();
    end
    applyStimulus(6'h05, 1'b1);
    checkOutput("fetch4_memread", 32'(MemRead), 32'd1);
    checkOutput("fetch4_irwrite", 32'(IRWrite), 32'd1);
    checkOutput("fetch4_pcwrite", 32'(PCWrite), 32'd1);
    tick();
    checkOutput("decode_state", 32'(state_o), 32'd1);
    checkOutput("decode_alusrcb", 32'(ALUSrcB), 32'd3);
    checkOutput("decode_illegal", 32'(illegal), 32'd0);
    tick();
    checkOutput("bne_state", 32'(state_o), 32'd8);
    checkOutput("bne_branchne", 32'(BranchNe), 32'd1);
    checkOutput("bne_branch", 32'(Branch), 32'd0);
    checkOutput("bne_aluop", 32'(ALUOp), 32'd1);
    checkOutput("bne_pcsource", 32'(PCSource), 32'd1);
    checkOutput("bne_alusrca", 32'(ALUSrcA), 32'd1);
    tick();
    applyStimulus(6'h04, 1'b1);
    tick();
    tick();
    checkOutput("beq_state", 32'(state_o), 32'd8);
    checkOutput("beq_branch", 32'(Branch), 32'd1);
    checkOutput("beq_branchne", 32'(BranchNe), 32'd0);
    tick();
    checkOutput("br_count", instr_count, 32'd8);

    // Unknown opcode retires from DECODE.
    applyStimulus(6'h3F, 1'b1);
    tick();
    checkOutput("ill_state", 32'(state_o), 32'd1);
    checkOutput("ill_pulse", 32'(illegal), 32'd1);
    checkOutput("ill_retire", 32'(retire), 32'd1);
    checkOutput("ill_regwrite", 32'(RegWrite), 32'd0);
    checkOutput("ill_memwrite", 32'(MemWrite), 32'd0);
    tick();
    checkOutput("ill_next_state", 32'(state_o), 32'd0);
    checkOutput("ill_next_pulse", 32'(illegal), 32'd0);
    checkOutput("ill_count", instr_count, 32'd9);

    // Asynchronous reset in the middle of a lw read wait.
    applyStimulus(6'h23, 1'b1);
    tick();
    tick();
    tick();
    applyStimulus(6'h23, 1'b0);
    checkOutput("memrd_state", 32'(state_o), 32'd3);
    checkOutput("memrd_iord", 32'(IorD), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("arst_state", 32'(state_o), 32'd0);
    checkOutput("arst_memread", 32'(MemRead), 32'd1);
    checkOutput("arst_iord", 32'(IorD), 32'd0);
    checkOutput("arst_irwrite", 32'(IRWrite), 32'd0);
    checkOutput("arst_count", instr_count, 32'd0);
    #2;
    rst = 1'b0;

    // sw parked in MEMWR with memory never ready.
    applyStimulus(6'h2B, 1'b1);
    tick();
    tick();
    tick();
    applyStimulus(6'h2B, 1'b0);
`ifdef MC_CTRL_TIMEOUT_EN
    for (int i = 0; i < 5; i++) begin
      checkOutput("to_wait_state", 32'(state_o), 32'd5);
      checkOutput("to_wait_memwrite", 32'(MemWrite), 32'd1);
      checkOutput("to_wait_err", 32'(err_timeout), 32'd0);
      tick();
    end
    checkOutput("halt_state", 32'(state_o), 32'd15);
    checkOutput("halt_err", 32'(err_timeout), 32'd1);
    checkOutput("halt_memwrite", 32'(MemWrite), 32'd0);
    checkOutput("halt_memread", 32'(MemRead), 32'd0);
    applyStimulus(6'h2B, 1'b1);
    tick();
    tick();
    checkOutput("halt_hold_state", 32'(state_o), 32'd15);
    checkOutput("halt_hold_err", 32'(err_timeout), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("halt_rst_state", 32'(state_o), 32'd0);
    checkOutput("halt_rst_err", 32'(err_timeout), 32'd0);
    #2;
    rst = 1'b0;
`else
    for (int i = 0; i < 1000; i++) begin
      checkOutput("wait_state", 32'(state_o), 32'd5);
      checkOutput("wait_err", 32'(err_timeout), 32'd0);
      tick();
    end
    checkOutput("wait_retire", 32'(retire), 32'd0);
    applyStimulus(6'h2B, 1'b1);
    checkOutput("wr_done_retire", 32'(retire), 32'd1);
    tick();
    checkOutput("wr_done_state", 32'(state_o), 32'd0);
    checkOutput("wr_done_count", instr_count, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
